display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 84 ++++++++
 tb/tb_display_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for an 8-digit display.
// A prescaler divides clk into DIV-cycle digit slots. sel steps through digits 0..7.
// frame_tick pulses for one cycle after sel wraps from 7 back to 0.
// The an output drives the active-low anodes. It is decoded combinationally from the
// registered state, en and digit_en.
// Optional feature: define SCAN_BLANK_EN to force all anodes off for the first BLANK
// cycles of every slot (anti-ghosting). Without it, BLANK has no effect.
module display_scan_ctrl #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_en,
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  // One extra bit so BLANK (< DIV <= 2**CNT_W) always fits without truncation.
  localparam logic [CNT_W:0]   BLANK_C = (CNT_W + 1)'(BLANK);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             frame_tick_q, frame_tick_d;
  logic             slot_end;
  logic             blank;

  assign slot_end = (cnt_q == CNT_MAX);

  // Next-state logic: the counter and select only move while enabled.
  // A slot always runs its full DIV cycles, whatever digit_en says.
  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    frame_tick_d = 1'b0;
    if (en) begin
      if (slot_end) begin
        cnt_d        = '0;
        sel_d        = sel_q + 3'd1;
        frame_tick_d = (sel_q == 3'd7);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // With blanking compiled out, BLANK_ON folds this to constant 0.
  assign blank = BLANK_ON && ({1'b0, cnt_q} < BLANK_C);

  // Anode decode: light only the selected digit, when enabled, unmasked and not blanked.
  always_comb begin
    an = 8'hFF;
    if (en && digit_en[sel_q] && !blank) begin
      an[sel_q] = 1'b0;
    end
  end

  assign sel        = sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl with DIV=4 and BLANK=1.
// It follows SCAN_BLANK_EN the same way the design does.
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] digit_en;
  logic [2:0] sel;
  logic [7:0] an;
  logic       frame_tick;

  display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_en   (digit_en),
    .sel        (sel),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] an;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   ft_cycles[$];

  // Reference state: what the counter and select should hold after each edge.
  int   m_cnt;
  int   m_sel;
  bit   m_ft;
  int   cyc;
  int   n_checks;
  int   n_pass;

  function automatic logic [7:0] model_an(input logic en_v, input logic [7:0] de_v);
    bit lit;
    lit = en_v && de_v[m_sel[2:0]] && !(BLANK_ON && (m_cnt < BLANK));
    return lit ? ~(8'h01 << m_sel) : 8'hFF;
  endfunction

  // Apply one clock cycle of stimulus, predict the result, then check the DUT.
  task automatic step(input logic en_v, input logic [7:0] de_v, input logic rst_v);
    exp_t e;
    @(negedge clk);
    en       = en_v;
    digit_en = de_v;
    rst_n    = rst_v;
    if (!rst_v) begin
      m_cnt = 0; m_sel = 0; m_ft = 1'b0;
    end else if (en_v) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_ft  = (m_sel == 7);
        m_sel = (m_sel + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
        m_ft  = 1'b0;
      end
    end else begin
      m_ft = 1'b0;
    end
    exp_q.push_back('{sel: m_sel[2:0], an: model_an(en_v, de_v), ft: m_ft});
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    e = exp_q.pop_front();
    n_checks = n_checks + 1;
    assert (sel === e.sel) n_pass = n_pass + 1;
    else $error("FAIL sel cyc=%0d got=%0d want=%0d", cyc, sel, e.sel);
    n_checks = n_checks + 1;
    assert (an === e.an) n_pass = n_pass + 1;
    else $error("FAIL an cyc=%0d sel=%0d got=%h want=%h", cyc, e.sel, an, e.an);
    n_checks = n_checks + 1;
    assert (frame_tick === e.ft) n_pass = n_pass + 1;
    else $error("FAIL frame_tick cyc=%0d got=%b want=%b", cyc, frame_tick, e.ft);
    if (frame_tick === 1'b1) ft_cycles.push_back(cyc);
  endtask

  initial begin
    int gap;
    n_checks = 0; n_pass = 0; cyc = 0;
    m_cnt = 0; m_sel = 0; m_ft = 1'b0;
    rst_n = 1'b0; en = 1'b1; digit_en = 8'hFF;

    // Reset held for two cycles with en=1.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);

    // Full-mask scan across more than two frames; record the frame_tick spacing.
    ft_cycles.delete();
    for (int i = 0; i < 72; i++) step(1'b1, 8'hFF, 1'b1);
    n_checks = n_checks + 1;
    assert (ft_cycles.size() >= 2) n_pass = n_pass + 1;
    else $error("FAIL ft_count got=%0d want>=2", ft_cycles.size());
    if (ft_cycles.size() >= 2) begin
      gap = ft_cycles[1] - ft_cycles[0];
      n_checks = n_checks + 1;
      assert (gap == 8 * DIV) n_pass = n_pass + 1;
      else $error("FAIL ft_gap got=%0d want=%0d", gap, 8 * DIV);
    end

    // Odd digits only. Even slots stay dark, and the timing stays the same.
    for (int i = 0; i < 36; i++) step(1'b1, 8'hAA, 1'b1);

    // Pause at sel=3, cnt=2 for five cycles, then resume.
    for (int i = 0; i < 40 && !(m_sel == 3 && m_cnt == 2); i++) step(1'b1, 8'hFF, 1'b1);
    n_checks = n_checks + 1;
    assert (sel === 3'd3) n_pass = n_pass + 1;
    else $error("FAIL pause_point got=%0d want=3", sel);
    for (int i = 0; i < 5; i++) step(1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hFF, 1'b1);

    // Drop en exactly on the slot-end cycle; no advance until re-enabled.
    for (int i = 0; i < 8 && m_cnt != DIV - 1; i++) step(1'b1, 8'h5F, 1'b1);
    step(1'b0, 8'h5F, 1'b1);
    step(1'b0, 8'h5F, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h5F, 1'b1);

    // Reset in the middle of a frame at sel=5, cnt=2.
    for (int i = 0; i < 40 && !(m_sel == 5 && m_cnt == 2); i++) step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'hFF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
